player_anim: RTL and testbench

Sprite animation controller downstream of the player physics block. Each frame it samples the physics block's sprite-origin outputs (Ball_X, Ball_Y) and facing bit (move_x_dir), derives per-frame displacement, classifies the player as idle/running/jumping/falling/landing, and emits a sprite frame index plus horizontal flip. The index and flip feed the sprite ROM address logic in the colour mapper.

---
 rtl/anim_pkg.sv | 45 ++++
 rtl/anim_motion_detect.sv | 34 +++
 rtl/player_anim.sv | 161 ++++++++++++++++
 tb/tb_player_anim.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared types and constants for the player sprite animation block.
// State codes, sprite-sheet bases, default frame counts, small helpers.
package anim_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_JUMP = 3'd2,
    S_FALL = 3'd3,
    S_LAND = 3'd4
  } anim_state_e;

  localparam logic [3:0] BASE_IDLE = 4'd0;
  localparam logic [3:0] BASE_RUN  = 4'd2;
  localparam logic [3:0] BASE_JUMP = 4'd8;
  localparam logic [3:0] BASE_FALL = 4'd9;
  localparam logic [3:0] BASE_LAND = 4'd10;

  localparam int RUN_FRAMES_DEF  = 6;
  localparam int IDLE_FRAMES_DEF = 2;
  localparam int POSE_FRAMES     = 1;

  function automatic logic [3:0] state_base(
    input anim_state_e s
  );
    logic [3:0] b;
    b = BASE_IDLE;
    unique case (s)
      S_IDLE:  b = BASE_IDLE;
      S_RUN:   b = BASE_RUN;
      S_JUMP:  b = BASE_JUMP;
      S_FALL:  b = BASE_FALL;
      S_LAND:  b = BASE_LAND;
      default: b = BASE_IDLE;
    endcase
    return b;
  endfunction

  // Magnitude of a 10-bit two's complement value; -512 maps to 512,
  // which is still representable as an unsigned 10-bit number.
  function automatic logic [9:0] abs10(input logic [9:0] v);
    return v[9] ? (~v + 10'd1) : v;
  endfunction

endpackage

// File: rtl/anim_motion_detect.sv
// Per-frame motion classifier: displacement flags from current vs previous
// sprite origin. In: Ball_X/Ball_Y, prev_x/prev_y. Out: motion flags.
module anim_motion_detect
  import anim_pkg::*;
#(
  parameter int MAX_STEP = 16
) (
  input  logic [9:0] Ball_X,
  input  logic [9:0] Ball_Y,
  input  logic [9:0] prev_x,
  input  logic [9:0] prev_y,
  output logic       dx_nz,
  output logic       dy_neg,
  output logic       dy_pos,
  output logic       dy_zero,
  output logic       discont
);

  localparam logic [9:0] STEP = 10'(MAX_STEP);

  logic [9:0] dx;
  logic [9:0] dy;

  always_comb begin
    dx      = Ball_X - prev_x;
    dy      = Ball_Y - prev_y;
    dx_nz   = |dx;
    dy_zero = ~|dy;
    dy_neg  = dy[9];
    dy_pos  = ~dy[9] & (|dy);
    discont = (abs10(dx) > STEP) || (abs10(dy) > STEP);
  end

endmodule

// File: rtl/player_anim.sv
// Sprite animation FSM: idle/run/jump/fall/land from per-frame motion.
// In: Reset, frame_clk, Ball_X/Y, move_x_dir. Out: sprite_idx/flip, state.
module player_anim
  import anim_pkg::*;
#(
  parameter int RUN_FRAMES     = RUN_FRAMES_DEF,
  parameter int RUN_DIV        = 4,
  parameter int IDLE_FRAMES    = IDLE_FRAMES_DEF,
  parameter int IDLE_DIV       = 16,
  parameter int LAND_HOLD      = 4,
  parameter int GROUND_CONFIRM = 3,
  parameter int MAX_STEP       = 16
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] Ball_X,
  input  logic [9:0] Ball_Y,
  input  logic       move_x_dir,
  output logic [3:0] sprite_idx,
  output logic       sprite_flip,
  output logic [2:0] anim_state
);

  localparam logic [7:0] RUN_DM  = 8'(RUN_DIV - 1);
  localparam logic [7:0] IDLE_DM = 8'(IDLE_DIV - 1);
  localparam logic [7:0] RUN_FM  = 8'(RUN_FRAMES - 1);
  localparam logic [7:0] IDLE_FM = 8'(IDLE_FRAMES - 1);
  localparam logic [7:0] HOLD_M  = 8'(LAND_HOLD - 1);
  localparam logic [7:0] GC      = 8'(GROUND_CONFIRM);

  anim_state_e state, state_n;
  logic [9:0]  prev_x, prev_y;
  logic        pos_valid;
  logic [7:0]  flat_cnt, flat_n;
  logic [7:0]  div_cnt, div_n;
  logic [7:0]  frame_cnt, frame_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [7:0]  div_lim, frm_lim;
  logic [3:0]  idx_n;
  logic        flat_hit;
  logic        dx_nz, dy_neg, dy_pos, dy_zero, discont;

  anim_motion_detect #(
    .MAX_STEP(MAX_STEP)
  ) u_motion (
    .Ball_X (Ball_X),
    .Ball_Y (Ball_Y),
    .prev_x (prev_x),
    .prev_y (prev_y),
    .dx_nz  (dx_nz),
    .dy_neg (dy_neg),
    .dy_pos (dy_pos),
    .dy_zero(dy_zero),
    .discont(discont)
  );

  always_comb begin
    state_n  = state;
    flat_n   = flat_cnt;
    div_n    = div_cnt;
    frame_n  = frame_cnt;
    hold_n   = hold_cnt;
    flat_hit = 1'b0;
    div_lim  = 8'd0;
    frm_lim  = 8'd0;
    // Pose states keep both limits at zero so they sit on frame 0.
    if (state == S_RUN) begin
      div_lim = RUN_DM;
      frm_lim = RUN_FM;
    end else if (state == S_IDLE) begin
      div_lim = IDLE_DM;
      frm_lim = IDLE_FM;
    end
    if (pos_valid) begin
      if (discont) begin
        state_n = S_IDLE;
        flat_n  = 8'd0;
        div_n   = 8'd0;
        frame_n = 8'd0;
        hold_n  = 8'd0;
      end else begin
        if (!dy_zero)
          flat_n = 8'd0;
        else if (flat_cnt != GC)
          flat_n = flat_cnt + 8'd1;
        flat_hit = (flat_n == GC);
        case (state)
          S_IDLE: begin
            if (dy_neg)      state_n = S_JUMP;
            else if (dy_pos) state_n = S_FALL;
            else if (dx_nz)  state_n = S_RUN;
          end
          S_RUN: begin
            if (dy_neg)      state_n = S_JUMP;
            else if (dy_pos) state_n = S_FALL;
            else if (!dx_nz) state_n = S_IDLE;
          end
          S_JUMP: begin
            if (dy_pos)        state_n = S_FALL;
            else if (flat_hit) state_n = S_LAND;
          end
          S_FALL: begin
            if (dy_neg)        state_n = S_JUMP;
            else if (flat_hit) state_n = S_LAND;
          end
          S_LAND: begin
            if (dy_neg)
              state_n = S_JUMP;
            else if (hold_cnt == HOLD_M)
              state_n = dx_nz ? S_RUN : S_IDLE;
          end
          default: state_n = S_IDLE;
        endcase
        if (state_n != state) begin
          div_n   = 8'd0;
          frame_n = 8'd0;
          hold_n  = 8'd0;
        end else begin
          if (state == S_LAND)
            hold_n = hold_cnt + 8'd1;
          if (div_cnt >= div_lim) begin
            div_n   = 8'd0;
            frame_n = (frame_cnt >= frm_lim) ? 8'd0 : frame_cnt + 8'd1;
          end else begin
            div_n = div_cnt + 8'd1;
          end
        end
      end
    end
    idx_n = state_base(state_n) + frame_n[3:0];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      prev_x      <= 10'd0;
      prev_y      <= 10'd0;
      pos_valid   <= 1'b0;
      flat_cnt    <= 8'd0;
      div_cnt     <= 8'd0;
      frame_cnt   <= 8'd0;
      hold_cnt    <= 8'd0;
      sprite_idx  <= 4'd0;
      sprite_flip <= 1'b0;
    end else begin
      state       <= state_n;
      prev_x      <= Ball_X;
      prev_y      <= Ball_Y;
      pos_valid   <= 1'b1;
      flat_cnt    <= flat_n;
      div_cnt     <= div_n;
      frame_cnt   <= frame_n;
      hold_cnt    <= hold_n;
      sprite_idx  <= idx_n;
      sprite_flip <= move_x_dir;
    end
  end

  assign anim_state = state;

endmodule

// File: tb/tb_player_anim.sv
// Self-checking bench for player_anim: directed scenarios plus a random
// walk, all checked against a tick-age based behavioural model.
module tb_player_anim;

  localparam int RUN_FRAMES     = 6;
  localparam int RUN_DIV        = 4;
  localparam int IDLE_FRAMES    = 2;
  localparam int IDLE_DIV       = 16;
  localparam int LAND_HOLD      = 4;
  localparam int GROUND_CONFIRM = 3;
  localparam int MAX_STEP       = 16;

  logic       Reset;
  logic       frame_clk;
  logic [9:0] Ball_X;
  logic [9:0] Ball_Y;
  logic       move_x_dir;
  logic [3:0] sprite_idx;
  logic       sprite_flip;
  logic [2:0] anim_state;

  int tests = 0;
  int fails = 0;

  // model: state code, ticks since state entry, flat run, last position
  int   m_state, m_age, m_flat, m_px, m_py, m_idx;
  bit   m_pv;
  logic m_flip;
  int   cx, cy;
  logic cdir;

  player_anim #(
    .RUN_FRAMES    (RUN_FRAMES),
    .RUN_DIV       (RUN_DIV),
    .IDLE_FRAMES   (IDLE_FRAMES),
    .IDLE_DIV      (IDLE_DIV),
    .LAND_HOLD     (LAND_HOLD),
    .GROUND_CONFIRM(GROUND_CONFIRM),
    .MAX_STEP      (MAX_STEP)
  ) dut (
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .Ball_X     (Ball_X),
    .Ball_Y     (Ball_Y),
    .move_x_dir (move_x_dir),
    .sprite_idx (sprite_idx),
    .sprite_flip(sprite_flip),
    .anim_state (anim_state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic int sdelta(input int a, input int b);
    int d;
    d = (a - b) & 1023;
    if (d >= 512) d -= 1024;
    return d;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_flat = 0;
    m_px = 0; m_py = 0; m_idx = 0;
    m_pv = 0; m_flip = 1'b0;
  endtask

  task automatic model_step();
    int dx, dy, ns;
    m_flip = cdir;
    if (!m_pv) begin
      m_pv = 1; m_px = cx; m_py = cy;
      return;
    end
    dx = sdelta(cx, m_px);
    dy = sdelta(cy, m_py);
    m_px = cx; m_py = cy;
    if (iabs(dx) > MAX_STEP || iabs(dy) > MAX_STEP) begin
      m_state = 0; m_age = 0; m_flat = 0;
    end else begin
      if (dy == 0)
        m_flat = (m_flat < GROUND_CONFIRM) ? m_flat + 1 : GROUND_CONFIRM;
      else
        m_flat = 0;
      case (m_state)
        0: ns = dy < 0 ? 2 : dy > 0 ? 3 : dx != 0 ? 1 : 0;
        1: ns = dy < 0 ? 2 : dy > 0 ? 3 : dx == 0 ? 0 : 1;
        2: ns = dy > 0 ? 3 : m_flat == GROUND_CONFIRM ? 4 : 2;
        3: ns = dy < 0 ? 2 : m_flat == GROUND_CONFIRM ? 4 : 3;
        default:
          ns = dy < 0 ? 2 :
               m_age == LAND_HOLD - 1 ? (dx != 0 ? 1 : 0) : 4;
      endcase
      if (ns != m_state) begin
        m_state = ns; m_age = 0;
      end else begin
        m_age++;
      end
    end
    case (m_state)
      0: m_idx = (m_age / IDLE_DIV) % IDLE_FRAMES;
      1: m_idx = 2 + (m_age / RUN_DIV) % RUN_FRAMES;
      2: m_idx = 8;
      3: m_idx = 9;
      default: m_idx = 10;
    endcase
  endtask

  task automatic tick(input int nx, input int ny, input logic nd);
    cx = nx & 1023;
    cy = ny & 1023;
    cdir = nd;
    Ball_X = cx[9:0];
    Ball_Y = cy[9:0];
    move_x_dir = cdir;
    @(posedge frame_clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Ball_X = '0; Ball_Y = '0; move_x_dir = 1'b0;
    cx = 0; cy = 0; cdir = 1'b0;
    model_reset();
    #2;
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0 ||
        sprite_flip !== 1'b0) begin
      fails++;
      $display("FAIL reset_async st=%0d idx=%0d fl=%0b want 0 0 0",
               anim_state, sprite_idx, sprite_flip);
    end
    repeat (2) @(posedge frame_clk);
    #1;
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0 ||
        sprite_flip !== 1'b0) begin
      fails++;
      $display("FAIL reset_held st=%0d idx=%0d fl=%0b want 0 0 0",
               anim_state, sprite_idx, sprite_flip);
    end
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 40; i++) begin
      tick(100, 300, 1'b0);
      tests++;
      if (anim_state !== 3'(m_state) || sprite_idx !== 4'(m_idx) ||
          sprite_flip !== m_flip) begin
        fails++;
        $display("FAIL idle[%0d] st=%0d idx=%0d fl=%0b want %0d %0d %0b",
                 i, anim_state, sprite_idx, sprite_flip,
                 m_state, m_idx, m_flip);
      end
      // tick 0 is the capture tick, so the toggle lands after tick 16
      if (i == 15 || i == 16 || i == 33) begin
        tests++;
        if (sprite_idx !== ((i == 16) ? 4'd1 : 4'd0)) begin
          fails++;
          $display("FAIL idle_toggle[%0d] idx=%0d", i, sprite_idx);
        end
      end
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 30; i++) begin
      tick(cx + 1, cy, 1'b0);
      tests++;
      if (anim_state !== 3'd1 || sprite_idx !== 4'(m_idx) ||
          m_state != 1) begin
        fails++;
        $display("FAIL run[%0d] st=%0d idx=%0d want 1 %0d",
                 i, anim_state, sprite_idx, m_idx);
      end
    end
    tick(cx + 1, cy, 1'b1);
    tests++;
    if (sprite_flip !== 1'b1 || anim_state !== 3'd1) begin
      fails++;
      $display("FAIL run_flip fl=%0b st=%0d want 1 1",
               sprite_flip, anim_state);
    end
  endtask

  task automatic test_jump();
    int prof[14] = '{-7, -6, -5, -4, -3, -2, -1, 0, 0, 1, 2, 3, 4, 5};
    logic [2:0] ws;
    logic [3:0] wi;
    for (int i = 0; i < 14; i++) begin
      tick(cx, cy + prof[i], cdir);
      ws = (i < 9) ? 3'd2 : 3'd3;
      wi = (i < 9) ? 4'd8 : 4'd9;
      tests++;
      if (anim_state !== ws || sprite_idx !== wi ||
          anim_state !== 3'(m_state)) begin
        fails++;
        $display("FAIL jump[%0d] st=%0d idx=%0d want %0d %0d",
                 i, anim_state, sprite_idx, ws, wi);
      end
    end
  endtask

  task automatic test_land(input int step);
    logic [2:0] ws;
    for (int i = 0; i < 3; i++) begin
      tick(cx + step, cy + 2, cdir);
      tests++;
      if (anim_state !== 3'd3 || sprite_idx !== 4'd9) begin
        fails++;
        $display("FAIL land_fall[%0d] st=%0d idx=%0d want 3 9",
                 i, anim_state, sprite_idx);
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick(cx + step, cy, cdir);
      ws = (i < 2) ? 3'd3 : (i < 6) ? 3'd4 : ((step != 0) ? 3'd1 : 3'd0);
      tests++;
      if (anim_state !== ws || anim_state !== 3'(m_state) ||
          sprite_idx !== 4'(m_idx)) begin
        fails++;
        $display("FAIL land[%0d] step=%0d st=%0d idx=%0d want %0d %0d",
                 i, step, anim_state, sprite_idx, ws, m_idx);
      end
    end
  endtask

  task automatic test_discont();
    for (int i = 0; i < 6; i++) tick(cx + 1, cy, cdir);
    tick(cx + 200, cy, cdir);
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0) begin
      fails++;
      $display("FAIL discont st=%0d idx=%0d want 0 0",
               anim_state, sprite_idx);
    end
    tick(cx, cy, cdir);
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0 || m_state != 0) begin
      fails++;
      $display("FAIL discont_after st=%0d idx=%0d want 0 0",
               anim_state, sprite_idx);
    end
  endtask

  task automatic test_land_interrupt();
    tick(cx, cy + 3, cdir);
    tick(cx, cy + 3, cdir);
    for (int i = 0; i < 4; i++) tick(cx, cy, cdir);
    tests++;
    if (anim_state !== 3'd4 || sprite_idx !== 4'd10) begin
      fails++;
      $display("FAIL land_pre st=%0d idx=%0d want 4 10",
               anim_state, sprite_idx);
    end
    tick(cx, cy - 2, cdir);
    tests++;
    if (anim_state !== 3'd2 || sprite_idx !== 4'd8 || m_state != 2) begin
      fails++;
      $display("FAIL land_jump st=%0d idx=%0d want 2 8",
               anim_state, sprite_idx);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) tick(cx, cy + 3, 1'b1);
    tests++;
    if (anim_state !== 3'd3 || sprite_flip !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset st=%0d fl=%0b want 3 1",
               anim_state, sprite_flip);
    end
    @(negedge frame_clk);
    #2;
    Reset = 1'b1;
    #1;
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0 ||
        sprite_flip !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset st=%0d idx=%0d fl=%0b want 0 0 0",
               anim_state, sprite_idx, sprite_flip);
    end
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    model_reset();
    tick(cx + 5, cy + 4, 1'b1);
    tests++;
    if (anim_state !== 3'd0 || sprite_idx !== 4'd0 || m_state != 0) begin
      fails++;
      $display("FAIL post_reset st=%0d idx=%0d want 0 0",
               anim_state, sprite_idx);
    end
    tick(cx + 1, cy, 1'b1);
    tests++;
    if (anim_state !== 3'd1 || sprite_idx !== 4'd2) begin
      fails++;
      $display("FAIL post_reset_run st=%0d idx=%0d want 1 2",
               anim_state, sprite_idx);
    end
  endtask

  task automatic test_random();
    int len, sx, sy;
    len = 0; sx = 0; sy = 0;
    for (int i = 0; i < 2000; i++) begin
      if (len == 0) begin
        len = $urandom_range(1, 12);
        sx = $urandom_range(0, 6) - 3;
        sy = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 8) - 4;
        if ($urandom_range(0, 3) == 0) cdir = ~cdir;
      end
      len--;
      if ($urandom_range(0, 99) < 2)
        tick(cx + $urandom_range(100, 900), cy, cdir);
      else
        tick(cx + sx, cy + sy, cdir);
      tests++;
      if (anim_state !== 3'(m_state) || sprite_idx !== 4'(m_idx) ||
          sprite_flip !== m_flip) begin
        fails++;
        $display("FAIL rand[%0d] st=%0d idx=%0d fl=%0b want %0d %0d %0b",
                 i, anim_state, sprite_idx, sprite_flip,
                 m_state, m_idx, m_flip);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_run();
    test_jump();
    test_land(0);
    test_land(1);
    test_discont();
    test_land_interrupt();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
